// File: rtl/led_pkg.sv
// Shared definitions for the LED DAI transmitter.
// Contents: frame geometry constants, FSM state encoding and a small max helper.
package led_pkg;

    localparam int unsigned PIXEL_W       = 16;
    localparam int unsigned SCANLINES     = 32;
    localparam int unsigned CHANNELS      = 16;
    localparam int unsigned PIX_PER_FRAME = SCANLINES * CHANNELS;
    localparam int unsigned PIX_IDX_W     = 9;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StGap   = 2'd2,
        StFgap  = 2'd3
    } led_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_dai_tx_if.sv
// Pixel-word handshake between the display source and the DAI transmitter.
// Signals: pix_valid (source offers a word), pix_data (16-bit gray level),
//          pix_ready (transmitter can take a word this cycle).
// Modports: master = pixel source, slave = transmitter.
interface led_dai_tx_if;

    logic                         pix_valid;
    logic [led_pkg::PIXEL_W-1:0]  pix_data;
    logic                         pix_ready;

    modport master (
        output pix_valid,
        output pix_data,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        output pix_ready
    );

endinterface

// File: rtl/led_piso16.sv
// Parallel-in serial-out shift register, LSB first.
// Ports: clk_i clock, rst_i synchronous active-high clear, load_i parallel load
//        (wins over shift), shift_i shift right by one, data_i load value,
//        lsb_o current bit 0.
module led_piso16 #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [Width-1:0] data_i,
    output logic             lsb_o
);

    logic [Width-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = {1'b0, sr_q[Width-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign lsb_o = sr_q[0];

endmodule

// File: rtl/led_dai_tx.sv
// DAI serial transmitter for the LED driver (DCK domain).
// Takes 16-bit pixel words over a valid/ready handshake and sends each one
// LSB first on DAI inside a 16-cycle DEN burst, followed by PIX_GAP idle
// cycles; the last pixel of a frame adds FRAME_GAP more idle cycles and a
// frame_done pulse.
// Ports: DCK clock, rst synchronous active-high reset, pix_if handshake
//        (slave), DAI serial data, DEN data enable, busy (not idle),
//        pix_idx index of the next pixel to accept, frame_done end-of-frame pulse.
module led_dai_tx #(
    parameter int unsigned PIX_PER_FRAME = led_pkg::PIX_PER_FRAME,
    parameter int unsigned PIX_GAP       = 2,
    parameter int unsigned FRAME_GAP     = 4
) (
    input  logic               DCK,
    input  logic               rst,
    led_dai_tx_if.slave        pix_if,
    output logic               DAI,
    output logic               DEN,
    output logic               busy,
    output logic [8:0]         pix_idx,
    output logic               frame_done
);

    import led_pkg::*;

    localparam int unsigned MaxGap  = max_u(PIX_GAP, FRAME_GAP);
    localparam int unsigned GapCntW = (MaxGap > 2) ? $clog2(MaxGap) : 1;

    led_state_e           state_q, state_d;
    logic [3:0]           bit_cnt_q;
    logic [GapCntW-1:0]   gap_cnt_q;
    logic [PIX_IDX_W-1:0] pix_idx_q;
    logic                 frame_done_q;
    logic                 sr_lsb;

    logic gap_last, fgap_last, frame_last, accept;

    assign gap_last   = (gap_cnt_q == GapCntW'(PIX_GAP - 1));
    assign fgap_last  = (gap_cnt_q == GapCntW'(FRAME_GAP - 1));
    assign frame_last = (pix_idx_q == PIX_IDX_W'(PIX_PER_FRAME - 1));
    assign accept     = (state_q == StIdle) && pix_if.pix_valid;

    // State register
    always_ff @(posedge DCK) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pix_if.pix_valid) state_d = StShift;
            StShift: if (bit_cnt_q == 4'd15) state_d = StGap;
            StGap:   if (gap_last) state_d = frame_last ? StFgap : StIdle;
            StFgap:  if (fgap_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode: state and registered data only, never pix_valid/pix_data
    always_comb begin
        DEN              = 1'b0;
        DAI              = 1'b0;
        pix_if.pix_ready = 1'b0;
        busy             = 1'b1;
        unique case (state_q)
            StIdle: begin
                pix_if.pix_ready = 1'b1;
                busy             = 1'b0;
            end
            StShift: begin
                DEN = 1'b1;
                DAI = sr_lsb;
            end
            default: ;
        endcase
    end

    // Counters and frame bookkeeping
    always_ff @(posedge DCK) begin
        if (rst) begin
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            pix_idx_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            // 4-bit counter wraps 15 -> 0 exactly as SHIFT ends
            bit_cnt_q <= (state_q == StShift) ? bit_cnt_q + 4'd1 : 4'd0;

            // Restarts on every state change so GAP -> FGAP counts afresh
            if ((state_q == StGap || state_q == StFgap) && state_d == state_q) begin
                gap_cnt_q <= gap_cnt_q + GapCntW'(1);
            end else begin
                gap_cnt_q <= '0;
            end

            if (state_q == StGap && gap_last && !frame_last) begin
                pix_idx_q <= pix_idx_q + PIX_IDX_W'(1);
            end else if (state_q == StFgap && fgap_last) begin
                pix_idx_q <= '0;
            end

            frame_done_q <= (state_q == StFgap) && fgap_last;
        end
    end

    led_piso16 #(
        .Width (PIXEL_W)
    ) u_piso (
        .clk_i   (DCK),
        .rst_i   (rst),
        .load_i  (accept),
        .shift_i (state_q == StShift),
        .data_i  (pix_if.pix_data),
        .lsb_o   (sr_lsb)
    );

    assign pix_idx    = pix_idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_dai_tx.sv
// Self-checking bench for led_dai_tx: transaction-level timeline model,
// DEN/DAI receiver with word scoreboard, and hand-computed literal checks.
module tb_led_dai_tx;

    localparam int PG   = 2;
    localparam int FG   = 4;
    localparam int NPIX = 512;

    logic       DCK = 1'b0;
    logic       rst = 1'b1;
    logic       DAI, DEN, busy, frame_done;
    logic [8:0] pix_idx;

    led_dai_tx_if bus ();

    led_dai_tx #(
        .PIX_PER_FRAME (NPIX),
        .PIX_GAP       (PG),
        .FRAME_GAP     (FG)
    ) dut (
        .DCK        (DCK),
        .rst        (rst),
        .pix_if     (bus),
        .DAI        (DAI),
        .DEN        (DEN),
        .busy       (busy),
        .pix_idx    (pix_idx),
        .frame_done (frame_done)
    );

    always #5 DCK = ~DCK;

    int cyc = 0;
    always @(posedge DCK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: each accepted word owns a timeline measured in cycles since the
    // handshake edge: 1..16 burst, then PIX_GAP idle, then FRAME_GAP if last.
    bit          m_init   = 1'b0;
    bit          m_active = 1'b0;
    bit          m_last   = 1'b0;
    bit          m_fdone  = 1'b0;
    int          m_e      = 0;
    int          m_idx    = 0;
    logic [15:0] m_word   = '0;
    int          f_start  = 0;
    logic [15:0] exp_q[$];

    // Receiver
    bit          rx_in        = 1'b0;
    int          rx_len       = 0;
    int          rx_low       = PG;
    int          rx_cnt       = 0;
    logic [15:0] rx_word      = '0;
    logic [15:0] rx_last_word = '0;
    int          rx_last_len  = 0;
    int          fd_cnt       = 0;

    always @(negedge DCK) begin
        logic exp_den, exp_dai;
        logic [15:0] w;
        if (m_init) begin
            exp_den = m_active && (m_e <= 16);
            exp_dai = 1'b0;
            if (exp_den) exp_dai = m_word[m_e-1];
            chk("den", DEN, exp_den);
            chk("dai", DAI, exp_dai);
            chk("ready", bus.pix_ready, !m_active);
            chk("busy", busy, m_active);
            chk("pix_idx", pix_idx, m_idx);
            chk("frame_done", frame_done, m_fdone);

            if (DEN === 1'b1) begin
                if (!rx_in) begin
                    chk("den_low_gap", rx_low >= PG, 1);
                    rx_in   = 1'b1;
                    rx_len  = 0;
                    rx_word = '0;
                end
                if (rx_len < 16) rx_word[rx_len] = DAI;
                rx_len++;
            end else begin
                if (rx_in) begin
                    rx_in        = 1'b0;
                    rx_cnt++;
                    rx_last_word = rx_word;
                    rx_last_len  = rx_len;
                    chk("burst_len", rx_len, 16);
                    chk("rx_pending", exp_q.size(), 1);
                    if (exp_q.size() > 0) begin
                        w = exp_q.pop_front();
                        chk("rx_word", rx_word, w);
                    end
                    rx_low = 0;
                end
                rx_low++;
            end
            if (frame_done === 1'b1) fd_cnt++;
        end

        // Predict the state after the coming edge
        if (rst) begin
            m_init   = 1'b1;
            m_active = 1'b0;
            m_idx    = 0;
            m_fdone  = 1'b0;
            rx_in    = 1'b0;
            rx_low   = PG;
            exp_q.delete();
        end else begin
            m_fdone = 1'b0;
            if (!m_active) begin
                if (bus.pix_valid === 1'b1) begin
                    m_active = 1'b1;
                    m_e      = 1;
                    m_word   = bus.pix_data;
                    m_last   = (m_idx == NPIX - 1);
                    exp_q.push_back(bus.pix_data);
                    if (m_idx == 0) f_start = cyc + 1;
                end
            end else begin
                m_e++;
                if (m_e == 1 + 16 + PG + (m_last ? FG : 0)) begin
                    m_active = 1'b0;
                    if (m_last) begin
                        m_idx   = 0;
                        m_fdone = 1'b1;
                    end else begin
                        m_idx++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge DCK);
        #1;
    endtask

    task automatic do_reset();
        bus.pix_valid = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        int n;
        n = 0;
        while (bus.pix_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("send_ready", bus.pix_ready, 1);
        bus.pix_valid = 1'b1;
        bus.pix_data  = w;
        tick();
        bus.pix_valid = 1'b0;
        bus.pix_data  = 16'($urandom);
        repeat (1 + 16 + PG + 2) tick();
    endtask

    initial begin
        logic [15:0] lit;
        int n, fd0, rx0;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset values
        chk("rst_den", DEN, 0);
        chk("rst_dai", DAI, 0);
        chk("rst_ready", bus.pix_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_idx", pix_idx, 0);
        chk("rst_fd", frame_done, 0);

        // Single pixel A5C3: DAI 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1
        lit = 16'b1010_0101_1100_0011;
        bus.pix_valid = 1'b1;
        bus.pix_data  = 16'hA5C3;
        tick();
        bus.pix_valid = 1'b0;
        bus.pix_data  = 16'($urandom);
        for (int k = 1; k <= 16; k++) begin
            chk("t1_den_hi", DEN, 1);
            chk("t1_dai", DAI, lit[k-1]);
            bus.pix_valid = 1'($urandom_range(0, 1));
            bus.pix_data  = 16'($urandom);
            tick();
        end
        bus.pix_valid = 1'b0;
        chk("t1_den_lo17", DEN, 0);
        chk("t1_dai_lo17", DAI, 0);
        chk("t1_ready17", bus.pix_ready, 0);
        tick();
        chk("t1_den_lo18", DEN, 0);
        chk("t1_ready18", bus.pix_ready, 0);
        tick();
        chk("t1_ready19", bus.pix_ready, 1);
        chk("t1_idx19", pix_idx, 1);
        chk("t1_word", rx_last_word, 16'hA5C3);

        // Back-to-back full frame, pix_data = pixel index
        do_reset();
        rx0 = rx_cnt;
        fd0 = fd_cnt;
        bus.pix_valid = 1'b1;
        n = 0;
        while (frame_done !== 1'b1 && n < 11000) begin
            bus.pix_data = 16'(m_idx);
            tick();
            n++;
        end
        bus.pix_valid = 1'b0;
        chk("b2b_fd_seen", frame_done, 1);
        chk("b2b_frame_len", cyc - f_start + 1, 512 * 19 + 4);
        chk("b2b_idx", pix_idx, 0);
        chk("b2b_bursts", rx_cnt - rx0, 512);
        chk("b2b_last_word", rx_last_word, 16'd511);
        tick();
        chk("b2b_fd_pulses", fd_cnt - fd0, 1);
        chk("b2b_fd_single", frame_done, 0);

        // Stalled source: one valid pulse every 37 cycles
        rx0 = rx_cnt;
        fd0 = fd_cnt;
        for (int p = 0; p < NPIX; p++) begin
            bus.pix_valid = 1'b1;
            bus.pix_data  = 16'($urandom);
            tick();
            bus.pix_valid = 1'b0;
            bus.pix_data  = 16'($urandom);
            repeat (36) tick();
        end
        chk("stall_bursts", rx_cnt - rx0, 512);
        chk("stall_fd_pulses", fd_cnt - fd0, 1);
        chk("stall_idx", pix_idx, 0);

        // Random valid/data noise, including during SHIFT and GAP
        repeat (3000) begin
            bus.pix_valid = 1'($urandom_range(0, 1));
            bus.pix_data  = 16'($urandom);
            tick();
        end
        bus.pix_valid = 1'b0;
        repeat (30) tick();

        // Reset at bit 7 of pixel 300
        do_reset();
        bus.pix_valid = 1'b1;
        n = 0;
        while (!(m_active && m_idx == 300 && m_e == 8) && n < 8000) begin
            bus.pix_data = 16'($urandom);
            tick();
            n++;
        end
        chk("rst_mid_reached", n < 8000, 1);
        chk("rst_mid_den_before", DEN, 1);
        chk("rst_mid_idx_before", pix_idx, 300);
        bus.pix_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_den", DEN, 0);
        chk("rst_mid_dai", DAI, 0);
        chk("rst_mid_idx", pix_idx, 0);
        chk("rst_mid_ready", bus.pix_ready, 1);
        chk("rst_mid_busy", busy, 0);
        send_word(16'h3C5A);
        chk("rst_next_word", rx_last_word, 16'h3C5A);
        chk("rst_next_len", rx_last_len, 16);
        chk("rst_next_idx", pix_idx, 1);

        // Data extremes
        send_word(16'h0000);
        chk("zero_word", rx_last_word, 16'h0000);
        chk("zero_len", rx_last_len, 16);
        send_word(16'hFFFF);
        chk("ones_word", rx_last_word, 16'hFFFF);
        chk("ones_len", rx_last_len, 16);
        chk("ext_idx", pix_idx, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
